// File: rtl/circuito_exp4_pkg.sv
// Shared types and constants for the circuito_exp4 sequence-memory game.
package circuito_exp4_pkg;

    localparam int TIMEOUT_CICLOS = 3000;
    localparam int N_RODADAS      = 16;
    localparam int AW             = $clog2(N_RODADAS);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        NOVA_SEQ    = 4'h2,
        ESPERA      = 4'h3,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROX_JOGADA = 4'h6,
        PROX_SEQ    = 4'h7,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hC,
        FIM_ERRO    = 4'hE
    } estado_t;

    localparam logic [3:0] ROM_SEQ [N_RODADAS] = '{
        4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
        4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4
    };

endpackage

// File: rtl/circuito_exp4_if.sv
// Game I/O bundle: player inputs, status outputs and debug displays.
interface circuito_exp4_if;

    logic       iniciar;
    logic [3:0] botoes;
    logic       acertou;
    logic       errou;
    logic       pronto;
    logic [3:0] leds;
    logic       db_igual;
    logic [6:0] db_contagem;
    logic [6:0] db_memoria;
    logic [6:0] db_estado;
    logic [6:0] db_jogadafeita;
    logic [6:0] db_limite;
    logic       db_clock;
    logic       db_iniciar;
    logic       db_tem_jogada;
    logic       db_timeout;

    modport master (
        output iniciar, botoes,
        input  acertou, errou, pronto, leds, db_igual,
        input  db_contagem, db_memoria, db_estado,
        input  db_jogadafeita, db_limite, db_clock,
        input  db_iniciar, db_tem_jogada, db_timeout
    );

    modport slave (
        input  iniciar, botoes,
        output acertou, errou, pronto, leds, db_igual,
        output db_contagem, db_memoria, db_estado,
        output db_jogadafeita, db_limite, db_clock,
        output db_iniciar, db_tem_jogada, db_timeout
    );

endinterface

// File: rtl/circuito_exp4_hexa7seg.sv
// Hex digit to active-low 7-segment pattern, bit order gfedcba.
module circuito_exp4_hexa7seg (
    input  logic [3:0] hexa,
    output logic [6:0] display
);

    always_comb begin
        display = 7'h7F;
        unique case (hexa)
            4'h0: display = 7'h40;
            4'h1: display = 7'h79;
            4'h2: display = 7'h24;
            4'h3: display = 7'h30;
            4'h4: display = 7'h19;
            4'h5: display = 7'h12;
            4'h6: display = 7'h02;
            4'h7: display = 7'h78;
            4'h8: display = 7'h00;
            4'h9: display = 7'h10;
            4'hA: display = 7'h08;
            4'hB: display = 7'h03;
            4'hC: display = 7'h46;
            4'hD: display = 7'h21;
            4'hE: display = 7'h06;
            4'hF: display = 7'h0E;
            default: display = 7'h7F;
        endcase
    end

endmodule

// File: rtl/circuito_exp4.sv
// Sequence-memory game: control FSM plus counters, ROM, play register and comparator.
module circuito_exp4 #(
    parameter int TIMEOUT_CICLOS = circuito_exp4_pkg::TIMEOUT_CICLOS
) (
    input logic              clock,
    input logic              reset,
    circuito_exp4_if.slave   bus
);
    import circuito_exp4_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CICLOS);

    estado_t estado, proximo;

    logic [AW-1:0] endereco, limite;
    logic [3:0]    jogada_reg;
    logic [TW-1:0] tempo;
    logic          tem_jogada, tem_prev, jogada;
    logic          igual, estourou;
    logic          zera_end, zera_lim, zera_jog;
    logic          conta_end, conta_lim, carrega_jog;

    assign tem_jogada = |bus.botoes;
    assign jogada     = tem_jogada & ~tem_prev;
    assign igual      = (jogada_reg == ROM_SEQ[endereco]);
    assign estourou   = (tempo == TW'(TIMEOUT_CICLOS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= INICIAL;
        else       estado <= proximo;
    end

    always_comb begin
        proximo     = estado;
        zera_end    = 1'b0;
        zera_lim    = 1'b0;
        zera_jog    = 1'b0;
        conta_end   = 1'b0;
        conta_lim   = 1'b0;
        carrega_jog = 1'b0;
        unique case (estado)
            INICIAL: if (bus.iniciar) proximo = PREPARACAO;
            PREPARACAO: begin
                zera_end = 1'b1;
                zera_lim = 1'b1;
                zera_jog = 1'b1;
                proximo  = NOVA_SEQ;
            end
            NOVA_SEQ: begin
                zera_end = 1'b1;
                proximo  = ESPERA;
            end
            ESPERA: begin
                if (jogada)        proximo = REGISTRA;
                else if (estourou) proximo = FIM_TIMEOUT;
            end
            REGISTRA: begin
                carrega_jog = 1'b1;
                proximo     = COMPARA;
            end
            // limite==last is tested before any increment, so counters never wrap
            COMPARA: begin
                if (!igual)                             proximo = FIM_ERRO;
                else if (endereco != limite)            proximo = PROX_JOGADA;
                else if (limite == AW'(N_RODADAS - 1))  proximo = FIM_ACERTO;
                else                                    proximo = PROX_SEQ;
            end
            PROX_JOGADA: begin
                conta_end = 1'b1;
                proximo   = ESPERA;
            end
            PROX_SEQ: begin
                conta_lim = 1'b1;
                proximo   = NOVA_SEQ;
            end
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
                if (bus.iniciar) proximo = PREPARACAO;
            default: proximo = INICIAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            endereco   <= '0;
            limite     <= '0;
            jogada_reg <= '0;
            tempo      <= '0;
            tem_prev   <= 1'b0;
        end else begin
            tem_prev <= tem_jogada;
            if (zera_end)       endereco <= '0;
            else if (conta_end) endereco <= endereco + AW'(1);
            if (zera_lim)       limite <= '0;
            else if (conta_lim) limite <= limite + AW'(1);
            if (zera_jog)         jogada_reg <= '0;
            else if (carrega_jog) jogada_reg <= bus.botoes;
            // cleared whenever outside ESPERA, so each entry starts from zero
            if (estado == ESPERA) tempo <= tempo + TW'(1);
            else                  tempo <= '0;
        end
    end

    assign bus.acertou       = (estado == FIM_ACERTO);
    assign bus.errou         = (estado == FIM_ERRO) || (estado == FIM_TIMEOUT);
    assign bus.pronto        = bus.acertou || bus.errou;
    assign bus.db_timeout    = (estado == FIM_TIMEOUT);
    assign bus.leds          = jogada_reg;
    assign bus.db_igual      = igual;
    assign bus.db_clock      = clock;
    assign bus.db_iniciar    = bus.iniciar;
    assign bus.db_tem_jogada = tem_jogada;

    circuito_exp4_hexa7seg u_hex_cont (
        .hexa    (endereco),
        .display (bus.db_contagem)
    );
    circuito_exp4_hexa7seg u_hex_mem (
        .hexa    (ROM_SEQ[endereco]),
        .display (bus.db_memoria)
    );
    circuito_exp4_hexa7seg u_hex_est (
        .hexa    (estado),
        .display (bus.db_estado)
    );
    circuito_exp4_hexa7seg u_hex_jog (
        .hexa    (jogada_reg),
        .display (bus.db_jogadafeita)
    );
    circuito_exp4_hexa7seg u_hex_lim (
        .hexa    (limite),
        .display (bus.db_limite)
    );

endmodule

// File: tb/tb_circuito_exp4.sv
// Scoreboard bench for circuito_exp4 with a shortened play timeout.
module tb_circuito_exp4;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    circuito_exp4_if bus ();

    circuito_exp4 #(.TIMEOUT_CICLOS(20)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [3:0] SEQ [16] = '{
        4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
        4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4
    };

    typedef struct packed {
        logic [3:0] leds;
        logic       igual;
    } exp_t;

    exp_t sbq [$];
    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one COMPARA cycle per registered play
    always @(negedge clock) begin : mon
        exp_t e;
        if (reset === 1'b0 && bus.db_estado === SEG[5]) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("sb_leds", 32'(bus.leds), 32'(e.leds));
                chk("sb_igual", 32'(bus.db_igual), 32'(e.igual));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] b, input int pos);
        sbq.push_back(exp_t'{leds: b, igual: (b == SEQ[pos])});
        bus.botoes = b;
        cyc(10);
        bus.botoes = 4'h0;
        cyc(10);
    endtask

    task automatic play_round(input int lim);
        for (int i = 0; i <= lim; i++) press(SEQ[i], i);
    endtask

    task automatic start_game();
        bus.iniciar = 1'b1;
        cyc(5);
        bus.iniciar = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input logic [3:0] st,
                             input logic a, input logic e, input logic p,
                             input logic t);
        chk({tag, "_estado"}, 32'(bus.db_estado), 32'(SEG[st]));
        chk({tag, "_acertou"}, 32'(bus.acertou), 32'(a));
        chk({tag, "_errou"}, 32'(bus.errou), 32'(e));
        chk({tag, "_pronto"}, 32'(bus.pronto), 32'(p));
        chk({tag, "_timeout"}, 32'(bus.db_timeout), 32'(t));
    endtask

    initial begin
        int n;
        reset       = 1'b1;
        bus.iniciar = 1'b0;
        bus.botoes  = 4'h0;
        cyc(3);
        reset = 1'b0;
        cyc(20);
        chk_flags("idle", 4'h0, 0, 0, 0, 0);
        chk("idle_leds", 32'(bus.leds), 32'h0);
        chk("idle_limite", 32'(bus.db_limite), 32'(SEG[0]));

        start_game();
        play_round(0);
        chk("r0_limite", 32'(bus.db_limite), 32'(SEG[1]));
        chk("r0_estado", 32'(bus.db_estado), 32'(SEG[3]));
        chk("r0_contagem", 32'(bus.db_contagem), 32'(SEG[0]));

        play_round(1);
        play_round(2);
        chk("r2_limite", 32'(bus.db_limite), 32'(SEG[3]));
        chk("r2_errou", 32'(bus.errou), 32'h0);

        press(4'h1, 0);
        press(4'h2, 1);
        press(4'h2, 2);
        chk_flags("erro", 4'hE, 0, 1, 1, 0);

        start_game();
        chk_flags("restart", 4'h3, 0, 0, 0, 0);
        chk("restart_limite", 32'(bus.db_limite), 32'(SEG[0]));

        n = 0;
        while (!bus.db_timeout && n < 40) begin
            cyc(1);
            n++;
        end
        chk("timeout_lat", 32'(n), 32'd18);
        chk_flags("tmo", 4'hC, 0, 1, 1, 1);

        start_game();
        play_round(0);
        reset = 1'b1;
        #2;
        chk("async_rst_estado", 32'(bus.db_estado), 32'(SEG[0]));
        chk("async_rst_limite", 32'(bus.db_limite), 32'(SEG[0]));
        cyc(2);
        reset = 1'b0;
        cyc(2);

        start_game();
        for (int r = 0; r < 16; r++) play_round(r);
        chk_flags("win", 4'hA, 1, 0, 1, 0);
        cyc(5);
        chk_flags("win_hold", 4'hA, 1, 0, 1, 0);
        chk("sb_left", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/circuito_exp4.md
Name: circuito_exp4

Overview:
- "Genius"-style sequence-memory game for the DE0-CV FPGA, clocked at 1 kHz.
- In round k (k = 0..15) the player must reproduce the first k+1 entries of a fixed 16-entry sequence ROM on four push-buttons.
- A correct full round advances the game; a wrong play or a timeout ends it.
- Top-level block: FSM-based control unit plus datapath with counters, ROM, play register and comparator, and debug 7-segment outputs.

Parameters:
- TIMEOUT_CICLOS, 3000, clock cycles allowed in ESPERA_JOGADA before timeout (3 s at 1 kHz).
- N_RODADAS, 16, number of rounds and ROM depth; the counters are log2(N_RODADAS) = 4 bits wide.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; forces INICIAL and clears all registers.
- iniciar  in  1  level; starts or restarts a game.
- botoes  in  4  one-hot play buttons.
- acertou  out  1  high in FIM_ACERTO.
- errou  out  1  high in FIM_ERRO and FIM_TIMEOUT.
- pronto  out  1  high in any FIM_* state.
- leds  out  4  contents of the play register (last registered play).
- db_igual  out  1  comparator output (play register == ROM[endereco]).
- db_contagem  out  7  7-seg display of the address counter.
- db_memoria  out  7  7-seg display of ROM[endereco].
- db_estado  out  7  7-seg display of the state code.
- db_jogadafeita  out  7  7-seg display of the play register.
- db_limite  out  7  7-seg display of the round-limit counter.
- db_clock  out  1  copy of clock.
- db_iniciar  out  1  copy of iniciar.
- db_tem_jogada  out  1  OR of botoes.
- db_timeout  out  1  high in FIM_TIMEOUT.

Behaviour:
- One clock; reset is asynchronous and active-high (ports clock, reset). On reset:
  - state = INICIAL;
  - endereco, limite, play register and timeout counter = 0;
  - acertou, errou, pronto, db_timeout = 0.
- 7-seg outputs are active-low, bit order gfedcba, showing hex 0-F.
- Play detection: tem_jogada = |botoes. A registered rising-edge detector produces a 1-cycle pulse jogada. A button held for N cycles counts once.
- ROM contents, addresses 0..15: 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4 (4-bit one-hot values). Read is combinational.
- FSM, with the hex code shown on db_estado:
  - INICIAL (0): if iniciar, go to PREPARACAO.
  - PREPARACAO (1): clear endereco, limite and play register; go to NOVA_SEQ.
  - NOVA_SEQ (2): clear endereco; go to ESPERA.
  - ESPERA (3): clear timeout counter on entry and count each cycle here.
    - If jogada, go to REGISTRA.
    - Else if count reaches TIMEOUT_CICLOS-1, go to FIM_TIMEOUT.
  - REGISTRA (4): load botoes into the play register; go to COMPARA.
  - COMPARA (5):
    - If not igual, go to FIM_ERRO.
    - Else if endereco /= limite, go to PROX_JOGADA.
    - Else if limite == N_RODADAS-1, go to FIM_ACERTO.
    - Else go to PROX_SEQ.
  - PROX_JOGADA (6): endereco += 1; go to ESPERA.
  - PROX_SEQ (7): limite += 1; go to NOVA_SEQ.
  - FIM_ACERTO (A), FIM_ERRO (E), FIM_TIMEOUT (C): outputs hold. If iniciar, go to PREPARACAO; else stay.
- Outputs are Moore-decoded from the state register. acertou, errou and pronto therefore rise the cycle after the decision and stay high until iniciar is taken.
- iniciar is ignored outside INICIAL and the FIM_* states.
- A jogada pulse outside ESPERA is discarded.
- The 4-bit counters never wrap during play, because the limite==15 check precedes any increment.

Decomposition:
- Shared package holds:
  - state enum with the 4-bit codes above;
  - TIMEOUT_CICLOS and N_RODADAS defaults;
  - ROM constant array.
- One natural sub-module: hexa7seg (4-bit in, 7-bit active-low segments), instantiated five times.
- Counters, edge detector and comparator stay inline.

Test Plan:
- Reset pulse, then idle 20 cycles → state code 0; acertou = errou = pronto = 0; db_estado shows "0".
- iniciar high 5 cycles, then press 0001 for 10 cycles → play register = 0001 and db_igual = 1; limite goes 0→1; state returns to ESPERA (3) with endereco = 0.
- Rounds 1 and 2 played correctly (0001,0010, then 0001,0010,0100), each button held 10 cycles with 10-cycle gaps → limite = 3 after round 2; no errou.
- Round 3 entered as 0001,0010,0010 → at the third play db_igual = 0; state FIM_ERRO (E); errou = 1, pronto = 1, acertou = 0.
- From FIM_ERRO, iniciar for 5 cycles → PREPARACAO then ESPERA; errou = pronto = 0; limite = 0. Reset mid-game → INICIAL immediately, without waiting for a clock edge.
- Additional coverage:
  - In ESPERA with no press for TIMEOUT_CICLOS cycles (shorten to 20 in sim) → FIM_TIMEOUT; errou = db_timeout = pronto = 1.
  - All 16 rounds correct → FIM_ACERTO; acertou = pronto = 1.
